// File: rtl/perspective_divide_pkg.sv
// Shared fixed-point types and helpers for the vertex pipeline
// (matrix-vector multiplier and perspective divide).
package perspective_divide_pkg;

    localparam int DATAWIDTH = 18;
    localparam int FRACBITS  = 12;
    localparam int RBITS     = 2 * FRACBITS + 1;
    localparam int SMAX      = (1 << (DATAWIDTH - 1)) - 1;
    localparam int FX_ONE    = 1 << FRACBITS;
    localparam int DIVW      = DATAWIDTH + 1;
    localparam int PRODW     = 2 * DATAWIDTH;
    localparam int CNTW      = $clog2(RBITS);

    typedef logic signed [DATAWIDTH-1:0] fx_t;
    typedef fx_t vec3_t [3];
    typedef fx_t vec4_t [4];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_MUL  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    localparam logic signed [PRODW-1:0] SAT_HI = PRODW'(SMAX);
    localparam logic signed [PRODW-1:0] SAT_LO = -SAT_HI - PRODW'(1);

    // Clamp a double-width signed value into the fx_t range.
    function automatic fx_t saturate(input logic signed [PRODW-1:0] v);
        fx_t r;
        if (v > SAT_HI) begin
            r = fx_t'(SMAX);
        end else if (v < SAT_LO) begin
            r = fx_t'(-SMAX - 1);
        end else begin
            r = v[DATAWIDTH-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/perspective_divide_serial_recip_div.sv
// Bit-serial restoring divider computing 2^(2*FRACBITS) / divisor,
// one quotient bit per clock, MSB first, with a start/done handshake.
module perspective_divide_serial_recip_div
    import perspective_divide_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [DIVW-1:0]  i_divisor,
    output logic [RBITS-1:0] o_quotient,
    output logic             o_done
);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [DIVW-1:0]  rem_q, rem_d;
    logic [DIVW-1:0]  divisor_q, divisor_d;
    logic [RBITS-1:0] quo_q, quo_d;

    logic [DIVW:0]    rem_shift;
    logic [DIVW:0]    divisor_ext;
    logic             fits;

    // The dividend is a single 1 at bit RBITS-1, which is the first bit shifted in.
    assign rem_shift   = {rem_q, (cnt_q == CNTW'(RBITS - 1))};
    assign divisor_ext = {1'b0, divisor_q};
    assign fits        = (rem_shift >= divisor_ext);

    always_comb begin
        busy_d    = busy_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        quo_d     = quo_q;
        if (i_start) begin
            busy_d    = 1'b1;
            cnt_d     = CNTW'(RBITS - 1);
            rem_d     = '0;
            quo_d     = '0;
            divisor_d = i_divisor;
        end else if (busy_q) begin
            rem_d = DIVW'(fits ? (rem_shift - divisor_ext) : rem_shift);
            quo_d = {quo_q[RBITS-2:0], fits};
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            quo_q     <= quo_d;
        end
    end

    assign o_quotient = quo_q;
    assign o_done     = done_q;

endmodule

// File: rtl/perspective_divide.sv
// Perspective divide: clip-space (x, y, z, w) to NDC by multiplying x, y, z
// with a serially computed 1/w; vertices with w <= 0 are flagged as clipped.
module perspective_divide
    import perspective_divide_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  vec4_t i_v,
    input  logic  i_dv,
    output logic  o_ready,
    output vec3_t o_ndc,
    output logic  o_clip,
    output logic  o_dv
);

    state_t state_q, state_d;
    vec3_t  coord_q, coord_d;
    vec3_t  ndc_q, ndc_d;
    vec3_t  ndc_calc;
    logic   clip_q, clip_d;
    logic   out_clip_q, out_clip_d;
    logic   out_dv_q, out_dv_d;
    logic   ready_q, ready_d;

    logic                   div_start;
    logic                   div_done;
    logic [RBITS-1:0]       quotient;
    logic signed [DIVW-1:0] w_ext;
    logic [DIVW-1:0]        divisor_abs;
    fx_t                    recip;

    // One extra bit keeps |most-negative w| representable.
    assign w_ext       = {i_v[3][DATAWIDTH-1], i_v[3]};
    assign divisor_abs = w_ext[DIVW-1] ? unsigned'(-w_ext) : unsigned'(w_ext);
    assign div_start   = (state_q == S_IDLE) && i_dv;

    perspective_divide_serial_recip_div u_div (
        .clk        (clk),
        .rstn       (rstn),
        .i_start    (div_start),
        .i_divisor  (divisor_abs),
        .o_quotient (quotient),
        .o_done     (div_done)
    );

    assign recip = (quotient > RBITS'(SMAX)) ? fx_t'(SMAX) : quotient[DATAWIDTH-1:0];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_scale
            logic signed [PRODW-1:0] prod;
            assign prod         = PRODW'(coord_q[gi]) * PRODW'(recip);
            assign ndc_calc[gi] = saturate(prod >>> FRACBITS);
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        coord_d    = coord_q;
        ndc_d      = ndc_q;
        clip_d     = clip_q;
        out_clip_d = out_clip_q;
        out_dv_d   = out_dv_q;
        ready_d    = ready_q;
        case (state_q)
            S_IDLE: begin
                if (i_dv) begin
                    coord_d[0] = i_v[0];
                    coord_d[1] = i_v[1];
                    coord_d[2] = i_v[2];
                    clip_d     = (i_v[3] <= fx_t'(0));
                    ready_d    = 1'b0;
                    state_d    = S_DIV;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                for (int i = 0; i < 3; i++) begin
                    ndc_d[i] = clip_q ? fx_t'(0) : ndc_calc[i];
                end
                out_clip_d = clip_q;
                out_dv_d   = 1'b1;
                state_d    = S_OUT;
            end
            S_OUT: begin
                out_dv_d = 1'b0;
                ready_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            coord_q    <= '{default: '0};
            ndc_q      <= '{default: '0};
            clip_q     <= 1'b0;
            out_clip_q <= 1'b0;
            out_dv_q   <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            coord_q    <= coord_d;
            ndc_q      <= ndc_d;
            clip_q     <= clip_d;
            out_clip_q <= out_clip_d;
            out_dv_q   <= out_dv_d;
            ready_q    <= ready_d;
        end
    end

    assign o_ready = ready_q;
    assign o_ndc   = ndc_q;
    assign o_clip  = out_clip_q;
    assign o_dv    = out_dv_q;

endmodule

// File: tb/tb_perspective_divide.sv
// Directed scoreboard bench for perspective_divide.
module tb_perspective_divide;
    import perspective_divide_pkg::*;

    typedef struct {
        longint n0;
        longint n1;
        longint n2;
        longint clip;
    } exp_t;

    logic  clk;
    logic  rstn;
    vec4_t i_v;
    logic  i_dv;
    logic  o_ready;
    vec3_t o_ndc;
    logic  o_clip;
    logic  o_dv;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   dv_count = 0;
    exp_t sb[$];

    perspective_divide dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_v     (i_v),
        .i_dv    (i_dv),
        .o_ready (o_ready),
        .o_ndc   (o_ndc),
        .o_clip  (o_clip),
        .o_dv    (o_dv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        longint r;
        r = v;
        if (v > SMAX) r = SMAX;
        if (v < -SMAX - 1) r = -SMAX - 1;
        return r;
    endfunction

    // Reference: integer division for 1/w, independent of the serial algorithm.
    function automatic exp_t model(input longint x, input longint y, input longint z,
                                   input longint w);
        exp_t   e;
        longint recip;
        if (w <= 0) begin
            e.n0 = 0; e.n1 = 0; e.n2 = 0; e.clip = 1;
        end else begin
            recip = (longint'(1) << (2 * FRACBITS)) / w;
            if (recip > SMAX) recip = SMAX;
            e.n0   = sat((x * recip) >>> FRACBITS);
            e.n1   = sat((y * recip) >>> FRACBITS);
            e.n2   = sat((z * recip) >>> FRACBITS);
            e.clip = 0;
        end
        return e;
    endfunction

    // Scoreboard consumer: every o_dv pulse pops and compares one entry.
    always @(negedge clk) begin
        if (o_dv) begin
            exp_t e;
            dv_count++;
            check("dv_has_pending", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("ndc_x", o_ndc[0], e.n0);
                check("ndc_y", o_ndc[1], e.n1);
                check("ndc_z", o_ndc[2], e.n2);
                check("clip", longint'(o_clip), e.clip);
                $display("out: ndc=(%0d,%0d,%0d) clip=%0b", o_ndc[0], o_ndc[1], o_ndc[2], o_clip);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input longint x, input longint y, input longint z, input longint w,
                        input string tag);
        int lat;
        bit got;
        bit ready_bad;
        got = 0;
        ready_bad = 0;
        lat = 0;
        @(negedge clk);
        for (int k = 0; k < 40 && !o_ready; k++) @(negedge clk);
        check({tag, "_ready"}, longint'(o_ready), 1);
        i_v[0] = fx_t'(x); i_v[1] = fx_t'(y); i_v[2] = fx_t'(z); i_v[3] = fx_t'(w);
        i_dv = 1'b1;
        @(posedge clk);
        sb.push_back(model(x, y, z, w));
        $display("in : %s x=%0d y=%0d z=%0d w=%0d", tag, x, y, z, w);
        #1 i_dv = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (o_dv) begin
                got = 1;
                lat = k;
                break;
            end
            if (o_ready) ready_bad = 1;
        end
        check({tag, "_got_dv"}, longint'(got), 1);
        check({tag, "_latency"}, lat, 27);
        check({tag, "_busy_ready"}, longint'(ready_bad), 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_dv_width"}, longint'(o_dv), 0);
        check({tag, "_ready_after"}, longint'(o_ready), 1);
    endtask

    longint tx [3] = '{4096, 131071, 4096};
    longint ty [3] = '{-12288, -131072, -4096};
    longint tz [3] = '{2048, 0, 1};
    longint tw [3] = '{8192, 4096, 1};

    initial begin
        int n_acc;
        int dv_before;
        int vi;
        rstn = 1'b0;
        i_dv = 1'b0;
        i_v  = '{default: '0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", longint'(o_ready), 1);
        check("rst_dv", longint'(o_dv), 0);
        check("rst_clip", longint'(o_clip), 0);
        check("rst_ndc_x", o_ndc[0], 0);
        check("rst_ndc_y", o_ndc[1], 0);
        check("rst_ndc_z", o_ndc[2], 0);
        rstn = 1'b1;

        send(4096, -12288, 2048, 8192, "w2");
        send(131071, -131072, 0, 4096, "w1");
        send(4096, -4096, 1, 1, "wmin");
        send(4096, 4096, 4096, 0, "wzero");
        send(4096, 4096, 4096, -4096, "wneg");
        send(-5000, 7000, 100, -131072, "wmostneg");
        send(-1234, 30000, -77, 12000, "wodd");

        // i_dv held high while the vector changes every 30 cycles.
        n_acc = 0;
        dv_before = dv_count;
        @(negedge clk);
        i_dv = 1'b1;
        for (int c = 0; c < 90; c++) begin
            vi = c / 30;
            i_v[0] = fx_t'(tx[vi]); i_v[1] = fx_t'(ty[vi]);
            i_v[2] = fx_t'(tz[vi]); i_v[3] = fx_t'(tw[vi]);
            if (o_ready) begin
                sb.push_back(model(tx[vi], ty[vi], tz[vi], tw[vi]));
                n_acc++;
                $display("in : held cycle=%0d vec=%0d", c, vi);
            end
            @(negedge clk);
        end
        i_dv = 1'b0;
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        check("held_accepts", n_acc, 4);
        check("held_drained", sb.size(), 0);
        check("held_outputs", dv_count - dv_before, n_acc);

        // Reset pulse mid-division aborts the vector without an output.
        @(negedge clk);
        i_v[0] = fx_t'(4096); i_v[1] = fx_t'(0); i_v[2] = fx_t'(0); i_v[3] = fx_t'(8192);
        i_dv = 1'b1;
        @(posedge clk);
        #1 i_dv = 1'b0;
        $display("in : abort x=4096 w=8192");
        repeat (10) @(posedge clk);
        @(negedge clk);
        dv_before = dv_count;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", longint'(o_ready), 1);
        check("abort_dv", longint'(o_dv), 0);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_output", dv_count - dv_before, 0);
        send(4096, 0, 0, 8192, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
